// File: rtl/mm_out_drain_pkg.sv
// mm_out_drain_pkg: shared geometry and types for the matmul result drain.
//   LANES/PW/DEPTH : tile shape (16 lanes x 24b partial sums, 16 slices per tile)
//   TR/TC          : tile rows / tile columns of the 512x512 result
//   SW/AW          : slice width (384) and output address width (14)
package mm_out_drain_pkg;

    localparam int LANES = 16;
    localparam int PW    = 24;
    localparam int DEPTH = 16;
    localparam int TR    = 32;
    localparam int TC    = 32;

    localparam int SW = LANES * PW;
    localparam int IW = $clog2(DEPTH);
    localparam int RW = $clog2(TR);
    localparam int CW = $clog2(TC);
    localparam int AW = RW + CW + IW;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // Column address is tile_col*DEPTH + idx; with DEPTH a power of two this
    // is a plain concatenation.
    function automatic logic [AW-1:0] make_addr(
        input logic [RW-1:0] row,
        input logic [CW-1:0] col,
        input logic [IW-1:0] idx
    );
        return {row, col, idx};
    endfunction

endpackage

// File: rtl/mm_out_drain_tile_bank.sv
// mm_out_drain_tile_bank: one ping-pong bank holding a full output tile.
//   Flop-based DEPTH x SW register file, one write port, one combinational
//   read port. Contents are not reset.
//   i_clk  : clock
//   we     : write enable
//   waddr  : write slice index
//   wdata  : write slice data
//   raddr  : read slice index
//   rdata  : read slice data (combinational)
module mm_out_drain_tile_bank
    import mm_out_drain_pkg::*;
(
    input  logic          i_clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [SW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [SW-1:0] rdata
);

    logic [SW-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mm_out_drain.sv
// mm_out_drain: consumer end of the matmul result path.
//   Captures 16-beat tile bursts into two ping-pong banks and streams each
//   tile out one 384-bit slice per accepted beat, tagged with its position in
//   the output matrix. Pulses o_mtrx_done once the last slice of tile (31,31)
//   is accepted.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_start             : synchronous clear, highest priority
//   i_res_valid/idx/data: incoming result beat
//   o_valid/i_ready     : output handshake
//   o_data/o_addr       : output slice and {row_blk, col} address
//   o_mtrx_done         : one-cycle pulse after last slice of the matrix
//   o_overrun           : sticky, a beat arrived for a full bank
//
// state   | meaning
// S_IDLE  | no bank ready to stream, o_valid low
// S_DRAIN | streaming bank[rd_bank] slice rd_idx, o_valid high
module mm_out_drain
    import mm_out_drain_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_res_valid,
    input  logic [IW-1:0] i_res_idx,
    input  logic [SW-1:0] i_res_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [SW-1:0] o_data,
    output logic [AW-1:0] o_addr,
    output logic          o_mtrx_done,
    output logic          o_overrun
);

    state_t        state, state_nxt;
    logic [1:0]    full;
    logic          wr_bank, rd_bank;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [RW-1:0] bank_row [2];
    logic [CW-1:0] bank_col [2];
    logic [IW-1:0] rd_idx;
    logic [SW-1:0] bank_rdata [2];

    logic wr_ok, fill_done, drop, accept, last_accept, last_tile;

    assign wr_ok       = i_res_valid & ~full[wr_bank] & ~i_start;
    assign fill_done   = wr_ok & (i_res_idx == IW'(DEPTH - 1));
    assign drop        = i_res_valid & full[wr_bank] & ~i_start;
    assign accept      = (state == S_DRAIN) & i_ready;
    assign last_accept = accept & (rd_idx == IW'(DEPTH - 1));
    assign last_tile   = (bank_row[rd_bank] == RW'(TR - 1)) &
                         (bank_col[rd_bank] == CW'(TC - 1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        mm_out_drain_tile_bank u_bank (
            .i_clk (i_clk),
            .we    (wr_ok & (wr_bank == 1'(b))),
            .waddr (i_res_idx),
            .wdata (i_res_data),
            .raddr (rd_idx),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_valid   = 1'b0;
        o_data    = '0;
        o_addr    = '0;
        case (state)
            S_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_valid = 1'b1;
                o_data  = bank_rdata[rd_bank];
                o_addr  = make_addr(bank_row[rd_bank], bank_col[rd_bank], rd_idx);
                // Back-to-back only when the other bank was already full
                // before this edge; a fill landing now costs one idle cycle.
                if (last_accept && !full[~rd_bank]) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (i_start) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full        <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_row      <= '0;
            wr_col      <= '0;
            bank_row    <= '{default: '0};
            bank_col    <= '{default: '0};
            rd_idx      <= '0;
            o_mtrx_done <= 1'b0;
            o_overrun   <= 1'b0;
        end else if (i_start) begin
            full        <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_row      <= '0;
            wr_col      <= '0;
            bank_row    <= '{default: '0};
            bank_col    <= '{default: '0};
            rd_idx      <= '0;
            o_mtrx_done <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_mtrx_done <= last_accept & last_tile;
            if (drop) begin
                o_overrun <= 1'b1;
            end
            // fill_done and last_accept always address different banks:
            // a fill needs its bank empty, a drain needs its bank full.
            if (fill_done) begin
                full[wr_bank]     <= 1'b1;
                wr_bank           <= ~wr_bank;
                bank_row[wr_bank] <= wr_row;
                bank_col[wr_bank] <= wr_col;
                if (wr_col == CW'(TC - 1)) begin
                    wr_col <= '0;
                    wr_row <= wr_row + 1'b1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
            if (accept) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (last_accept) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_mm_out_drain.sv
// tb_mm_out_drain: scoreboard bench for mm_out_drain.
module tb_mm_out_drain;
    import mm_out_drain_pkg::*;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_res_valid = 1'b0;
    logic [3:0]    i_res_idx = '0;
    logic [383:0]  i_res_data = '0;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [383:0]  o_data;
    logic [13:0]   o_addr;
    logic          o_mtrx_done;
    logic          o_overrun;

    mm_out_drain dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_res_valid (i_res_valid),
        .i_res_idx   (i_res_idx),
        .i_res_data  (i_res_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_addr      (o_addr),
        .o_mtrx_done (o_mtrx_done),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [383:0] data;
        logic [13:0]  addr;
    } beat_t;

    beat_t sb_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    done_count = 0;
    int    fill_cnt = 0;
    int    burst_tag = 0;
    logic [13:0] last_addr = '0;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane g of slice idx of burst tag: {tag[11:0], idx, g, 4'h5}
    function automatic logic [383:0] mk_data(input int tag, input int idx);
        logic [383:0] d;
        logic [11:0]  t;
        logic [3:0]   x;
        logic [3:0]   gg;
        d = '0;
        t = tag[11:0];
        x = idx[3:0];
        for (int g = 0; g < 16; g++) begin
            gg = g[3:0];
            d[g*24 +: 24] = {t, x, gg, 4'h5};
        end
        return d;
    endfunction

    // Tile k of the matrix in fill order: row k/32, col k%32.
    function automatic logic [13:0] exp_addr(input int k, input int idx);
        int rr;
        int cc;
        rr = (k / 32) % 32;
        cc = k % 32;
        return {rr[4:0], cc[4:0], idx[3:0]};
    endfunction

    // Monitor: pops the scoreboard on every accepted beat, checks hold
    // stability under stall and the done pulse position.
    logic         prev_stall = 1'b0;
    logic         prev_final = 1'b0;
    logic [383:0] held_d = '0;
    logic [13:0]  held_a = '0;
    beat_t        mon_e;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_stall = 1'b0;
            prev_final = 1'b0;
        end else begin
            if (prev_stall && o_valid) begin
                check("hold_data", o_data, held_d);
                check("hold_addr", o_addr, held_a);
            end
            if (prev_final || o_mtrx_done) begin
                check("mtrx_done", o_mtrx_done, prev_final);
                if (o_mtrx_done) done_count++;
            end
            prev_final = 1'b0;
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got addr %0h expected no beat", o_addr);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("beat_data", o_data, mon_e.data);
                    check("beat_addr", o_addr, mon_e.addr);
                    prev_final = (mon_e.addr == 14'h3FFF);
                end
                last_addr = o_addr;
            end
            prev_stall = o_valid && !i_ready;
            held_d = o_data;
            held_a = o_addr;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        fill_cnt = 0;
    endtask

    task automatic send_burst(input bit expect_ok, input bit scramble);
        int tag;
        int idx;
        beat_t b;
        tag = burst_tag;
        burst_tag++;
        if (expect_ok) begin
            for (int i = 0; i < 16; i++) begin
                b.data = mk_data(tag, i);
                b.addr = exp_addr(fill_cnt, i);
                sb_q.push_back(b);
            end
            fill_cnt++;
        end
        for (int i = 0; i < 16; i++) begin
            idx = (scramble && i != 15) ? 14 - i : i;
            i_res_valid = 1'b1;
            i_res_idx   = idx[3:0];
            i_res_data  = mk_data(tag, idx);
            tick();
        end
        i_res_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, o_valid, 1'b0);
        check({tag, "_data"}, o_data, '0);
        check({tag, "_addr"}, o_addr, 14'h0);
        check({tag, "_done"}, o_mtrx_done, 1'b0);
        check({tag, "_overrun"}, o_overrun, 1'b0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int gaps;
        bit pat [4];
        int k;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (3) tick();
        check_idle_outputs("rst");
        i_rst_n = 1'b1;
        tick();
        check_idle_outputs("post_rst");

        // Single tile, ready high: latency and in-order addresses 0..15
        i_ready = 1'b1;
        send_burst(1'b1, 1'b0);
        check("lat_edge1_valid", o_valid, 1'b0);
        tick();
        check("lat_edge2_valid", o_valid, 1'b1);
        wait_drain(40, "single_drain");
        check("single_idle", o_valid, 1'b0);

        // Backpressure with scrambled write order; tile lands at col 1
        i_ready = 1'b0;
        send_burst(1'b1, 1'b1);
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            i_ready = pat[k % 4];
            tick();
            k++;
        end
        check("bp_drain", sb_q.size(), 0);
        i_ready = 1'b1;
        tick();
        check("bp_idle", o_valid, 1'b0);

        // Ping-pong: two tiles filled under stall, then 32 contiguous beats
        pulse_start();
        i_ready = 1'b0;
        send_burst(1'b1, 1'b0);
        send_burst(1'b1, 1'b0);
        repeat (3) tick();
        check("pp_no_overrun", o_overrun, 1'b0);
        check("pp_valid_stalled", o_valid, 1'b1);
        i_ready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 32; i++) begin
            if (!o_valid) gaps++;
            tick();
        end
        check("pp_gaps", gaps, 0);
        check("pp_idle", o_valid, 1'b0);
        check("pp_drained", sb_q.size(), 0);

        // Overrun: third burst dropped, counters frozen, sticky until start
        pulse_start();
        i_ready = 1'b0;
        send_burst(1'b1, 1'b0);
        send_burst(1'b1, 1'b0);
        send_burst(1'b0, 1'b0);
        check("ovr_set", o_overrun, 1'b1);
        i_ready = 1'b1;
        wait_drain(60, "ovr_drain");
        check("ovr_sticky", o_overrun, 1'b1);
        check("ovr_idle", o_valid, 1'b0);
        send_burst(1'b1, 1'b0);
        wait_drain(40, "ovr_next_tile");
        check("ovr_sticky2", o_overrun, 1'b1);
        pulse_start();
        check("ovr_cleared", o_overrun, 1'b0);

        // Full matrix at a 64-cycle producer period
        done_count = 0;
        i_ready = 1'b1;
        for (int t = 0; t < 1024; t++) begin
            send_burst(1'b1, 1'b0);
            repeat (48) tick();
        end
        wait_drain(100, "mtx_drain");
        repeat (2) tick();
        check("mtx_done_count", done_count, 1);
        check("mtx_last_addr", last_addr, 14'h3FFF);
        check("mtx_no_overrun", o_overrun, 1'b0);

        // Reset in the middle of a drain, then a fresh tile from address 0
        pulse_start();
        i_ready = 1'b0;
        send_burst(1'b1, 1'b0);
        tick();
        i_ready = 1'b1;
        repeat (7) tick();
        i_ready = 1'b0;
        check("mid_addr7", o_addr, 14'd7);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        sb_q.delete();
        fill_cnt = 0;
        #3;
        i_rst_n = 1'b1;
        tick();
        i_ready = 1'b1;
        send_burst(1'b1, 1'b0);
        wait_drain(40, "post_rst_drain");
        check("post_rst_idle", o_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
